mem_access_unit: RTL and testbench
==================================

# mem_access_unit

- CPU-side initiator for the word-wide `data_ram`: asynchronous read, write on the rising clock edge when `we` is high.
- Accepts one byte, halfword or word load/store request at a time and sign- or zero-extends loads.
- Has no byte enables, so sub-word stores use an internal read-modify-write.
- Sits between the CPU execute/memory stage and `data_ram`; drives `a`, `d` and `we` directly and reads `spo`.

## Interface
- ADDR_WIDTH, 15, word-address width of the attached RAM
- DATA_WIDTH, 32, RAM word width; only 32 is supported
- clk  input  1  clock; RAM writes and all state update on its rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE; a request is accepted on the edge where req_valid & req_ready
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word; 11 is treated as word
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (the low byte or half holds the value)
- resp_valid  output  1  one-cycle completion pulse; there is no backpressure
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned access, valid with resp_valid
- ram_a  output  ADDR_WIDTH  connects to RAM `a`, equal to req_addr[ADDR_WIDTH+1:2]; upper address bits are ignored, so addresses wrap
- ram_d  output  32  connects to RAM `d`
- ram_we  output  1  connects to RAM `we`
- ram_spo  input  32  connects to RAM `spo`; combinational read data

## Operation
- **States:** IDLE, ACCESS, WRITE, RESP. The request is captured into registers on acceptance.
- **IDLE:** asserts req_ready and goes to ACCESS on acceptance.
- **ACCESS, alignment:** a request is misaligned when (half and addr[0]) or (word and addr[1:0] ≠ 0).
  - Misaligned: ram_we = 0, no RAM access, go to RESP with err = 1.
- **ACCESS, load:**
  - ram_we = 0.
  - Extract the lane from ram_spo: byte lane = addr[1:0], half lane = addr[1]; little-endian.
  - Extend per req_signed, register the result, go to RESP.
- **ACCESS, word store:**
  - ram_we = 1, ram_d = wdata.
  - The RAM writes on the edge that leaves ACCESS; go to RESP.
- **ACCESS, sub-word store:**
  - ram_we = 0.
  - Merge the wdata byte or half into the ram_spo word at the addressed lane, register the merged word, go to WRITE.
- **WRITE:** ram_we = 1, ram_d = merged word, ram_a unchanged; go to RESP.
- **RESP:** resp_valid = 1 with registered rdata and err; go to IDLE.
- ram_we is decoded from registered state plus registered request only, and never depends on req_* inputs directly.
- ram_a and ram_d hold their captured values from ACCESS through RESP.
- In IDLE: ram_a and ram_d hold their last value and ram_we = 0.

## Timing
- **Reset values:** state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, ram_we 0, ram_a 0, ram_d 0.
- **Latency, counted from the accept edge (edge 0):**
  - Load, word store, error: resp_valid high in the cycle after edge 1.
  - Sub-word store: resp_valid high in the cycle after edge 2.
- **Throughput:** the next request can be accepted in the first cycle after RESP. Minimum spacing is 3 cycles, or 4 for a sub-word store.
- **Reset mid-operation:** ram_we falls immediately, asynchronously. A pending WRITE is abandoned and RAM keeps its old word. No response is issued.
- **Request inputs:** req_* are ignored outside IDLE. They need to be valid only in the accept cycle.

## Configuration
- **MAU_ALIGN_CHECK_EN defined:**
  - Misalignment is detected as above.
  - resp_err = 1, no RAM write, resp_rdata = 0.
- **MAU_ALIGN_CHECK_EN undefined:**
  - Alignment bits are forced to 0: bit 0 for half, bits 1:0 for word.
  - The access completes normally; resp_err is tied 0.

## Structure
- **Shared package mau_pkg:**
  - Size encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum: IDLE, ACCESS, WRITE, RESP.
- **Sub-module mau_lane (combinational):**
  - Load lane extraction with extension.
  - Store lane merge.
  - Instantiated once.

## Test plan
- **Word round trip:** store word 0xDEADBEEF to 0x40, then load word 0x40 → resp_rdata 0xDEADBEEF, err 0. Store latency is 2 cycles.
- **Byte merge:** RAM word at 0x40 = 0x11223344; store byte 0xAA to 0x42 → word becomes 0x11AA3344. ram_we is high for exactly one cycle, in WRITE. resp_valid comes 3 cycles after accept.
- **Sign/zero extension:** with 0x11AA3344 at 0x40:
  - Load signed byte at 0x42 → 0xFFFFFFAA.
  - Load unsigned → 0x000000AA.
  - Load signed half at 0x40 → 0x00003344.
- **Misaligned, MAU_ALIGN_CHECK_EN defined:** store word to 0x41 → err 1, RAM unchanged.
- **Misaligned, MAU_ALIGN_CHECK_EN undefined:** store word to 0x41 → writes word 0x40, err 0.
- **Reset during WRITE of a byte store:** ram_we drops in the same cycle, RAM word unchanged, no resp_valid. The next request is accepted normally.
- **Back-to-back traffic:** req_valid held high with 20 random requests checked against a reference memory model. Checks: req_ready is low outside IDLE, and address 0x0002_0000 wraps to word 0.

Source files
------------

// File: rtl/mau_pkg.sv
// mau_pkg: shared size encodings, FSM state type and a size helper for
// the memory access unit.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } mau_state_e;

    // Encodings 10 and 11 are both full-word accesses.
    function automatic logic is_word_size(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/mau_lane.sv
// mau_lane: combinational lane logic. Extracts and extends the addressed
// byte/half of a RAM word for loads, and merges store data into the
// addressed lane of a RAM word for sub-word stores. Little-endian.
module mau_lane
    import mau_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] mask;
    logic [31:0] ins;

    assign byte_sh = {lane_i, 3'b000};
    assign half_sh = {lane_i[1], 4'b0000};
    assign lane_b  = 8'(word_i >> byte_sh);
    assign lane_h  = 16'(word_i >> half_sh);

    // Select lane, extend loads and build the store insertion mask.
    always_comb begin
        load_o = word_i;
        mask   = 32'hFFFF_FFFF;
        ins    = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o = {{24{signed_i & lane_b[7]}}, lane_b};
                mask   = 32'h0000_00FF << byte_sh;
                ins    = {24'd0, wdata_i[7:0]} << byte_sh;
            end
            SZ_HALF: begin
                load_o = {{16{signed_i & lane_h[15]}}, lane_h};
                mask   = 32'h0000_FFFF << half_sh;
                ins    = {16'd0, wdata_i[15:0]} << half_sh;
            end
            default: begin
                load_o = word_i;
                mask   = 32'hFFFF_FFFF;
                ins    = wdata_i;
            end
        endcase
        merged_o = (word_i & ~mask) | ins;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-side load/store initiator for a word-wide RAM with
// asynchronous read and no byte enables. Sub-word stores are done as a
// read-modify-write (ACCESS reads and merges, WRITE writes back).
// Optional feature macro: MAU_ALIGN_CHECK_EN (misaligned accesses report
// resp_err instead of being silently aligned down).
//
// Handshake: a request is taken on the rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE. The response is
// a single-cycle resp_valid pulse with no backpressure.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [DATA_WIDTH-1:0] ram_d,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_spo,
    output mau_state_e            dbg_state
);

    localparam int AB = ADDR_WIDTH + 2;

    mau_state_e            state_q, state_d;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic [AB-1:0]         addr_q;
    logic [AB-1:0]         addr_in;
    logic [DATA_WIDTH-1:0] ram_d_q, ram_d_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  accept;
    logic                  misaligned;
    logic [31:0]           load_data;
    logic [31:0]           merged;
    logic                  unused_addr_hi;

    // Address bits above the RAM range are dropped, so addresses wrap.
    assign unused_addr_hi = ^req_addr[31:AB];

    assign req_ready  = (state_q == IDLE);
    assign accept     = req_valid & req_ready;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign ram_a      = addr_q[AB-1:2];
    assign ram_d      = ram_d_q;
    assign dbg_state  = state_q;

`ifdef MAU_ALIGN_CHECK_EN
    assign addr_in    = req_addr[AB-1:0];
    assign misaligned = ((size_q == SZ_HALF) && addr_q[0]) ||
                        (is_word_size(size_q) && (addr_q[1:0] != 2'b00));
`else
    // Without checking, alignment bits are cleared at capture time.
    always_comb begin
        addr_in = req_addr[AB-1:0];
        if (req_size == SZ_HALF) addr_in[0] = 1'b0;
        if (is_word_size(req_size)) addr_in[1:0] = 2'b00;
    end
    assign misaligned = 1'b0;
`endif

    mau_lane u_lane (
        .size_i   (size_q),
        .signed_i (signed_q),
        .lane_i   (addr_q[1:0]),
        .word_i   (ram_spo),
        .wdata_i  (ram_d_q),
        .load_o   (load_data),
        .merged_o (merged)
    );

    // Next-state, RAM write strobe and response data decode.
    always_comb begin
        state_d = state_q;
        ram_d_d = ram_d_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ram_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ram_d_d = req_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = '0;
                err_d   = 1'b0;
                if (misaligned) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (!we_q) begin
                    rdata_d = load_data;
                    state_d = RESP;
                end else if (is_word_size(size_q)) begin
                    ram_we  = 1'b1;
                    state_d = RESP;
                end else begin
                    ram_d_d = merged;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                ram_we  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops ram_we at once since it decodes state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Request capture on accept; RAM data and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            addr_q   <= '0;
            ram_d_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= addr_in;
            end
            ram_d_q <= ram_d_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and back-to-back random load/store traffic
// against a behavioural data_ram, with a reference memory and hand values.
`timescale 1ns/1ps
module tb_mem_access_unit;
    import mau_pkg::*;

    localparam int AW = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [AW-1:0] ram_a;
    logic [31:0] ram_d;
    logic        ram_we;
    logic [31:0] ram_spo;
    mau_state_e  dbg_state;

    logic [31:0] mem     [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    int n_chk = 0;
    int n_bad = 0;

    mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_a      (ram_a),
        .ram_d      (ram_d),
        .ram_we     (ram_we),
        .ram_spo    (ram_spo),
        .dbg_state  (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Behavioural data_ram: asynchronous read, write on rising edge.
    assign ram_spo = mem[ram_a];
    always @(posedge clk) if (ram_we) mem[ram_a] <= ram_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: expected response/latency/write count, updates ref_mem.
    // Latency is counted in cycles with the accept cycle as cycle 0.
    task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] e_rd, output logic e_err,
                         output int e_lat, output int e_we);
        logic [31:0]   a;
        logic [AW-1:0] wi;
        logic [31:0]   w;
        logic [7:0]    b;
        logic [15:0]   h;
        a = addr; e_rd = '0; e_err = 1'b0; e_lat = 2; e_we = 0;
`ifdef MAU_ALIGN_CHECK_EN
        if ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00)) begin
            e_err = 1'b1;
            return;
        end
`else
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz[1]) a[1:0] = 2'b00;
`endif
        wi = a[AW+1:2];
        w  = ref_mem[wi];
        b  = w[int'(a[1:0])*8 +: 8];
        h  = w[int'(a[1])*16 +: 16];
        if (!we) begin
            case (sz)
                2'b00:   e_rd = sg ? {{24{b[7]}}, b} : {24'd0, b};
                2'b01:   e_rd = sg ? {{16{h[15]}}, h} : {16'd0, h};
                default: e_rd = w;
            endcase
        end else begin
            e_we = 1;
            case (sz)
                2'b00: begin ref_mem[wi][int'(a[1:0])*8 +: 8] = wd[7:0]; e_lat = 3; end
                2'b01: begin ref_mem[wi][int'(a[1])*16 +: 16] = wd[15:0]; e_lat = 3; end
                default: ref_mem[wi] = wd;
            endcase
        end
    endtask

    // Driver: called at a falling edge; returns at the falling edge of the
    // response cycle. Request inputs are scrambled after acceptance.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd, input logic keep,
                          output logic [31:0] rd, output logic er,
                          output int lat, output int we_cnt, output int rdy_cnt);
        int guard;
        rd = '0; er = 1'b0; lat = 0; we_cnt = 0; rdy_cnt = 0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        if (!req_ready) begin
            chk("tmo_accept", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        req_valid = keep; req_we = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        while (!resp_valid && lat < 10) begin
            we_cnt += int'(ram_we); rdy_cnt += int'(req_ready);
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) chk("tmo_resp", 32'd0, 32'd1);
        we_cnt += int'(ram_we); rdy_cnt += int'(req_ready);
        rd = resp_rdata; er = resp_err;
    endtask

    task automatic run_op(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd, input logic keep,
                          output logic [31:0] rd);
        logic [31:0] e_rd;
        logic        e_err, er;
        int          e_lat, e_we, lat, we_cnt, rdy_cnt;
        model(we, sz, sg, addr, wd, e_rd, e_err, e_lat, e_we);
        do_req(we, sz, sg, addr, wd, keep, rd, er, lat, we_cnt, rdy_cnt);
        chk({tag, "_rdata"}, rd, e_rd);
        chk({tag, "_err"}, 32'(er), 32'(e_err));
        chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
        chk({tag, "_we_cycles"}, 32'(we_cnt), 32'(e_we));
        chk({tag, "_ready_busy"}, 32'(rdy_cnt), 32'd0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          rv_cnt;
        for (int i = 0; i < (1<<AW); i++) begin mem[i] = '0; ref_mem[i] = '0; end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_a", 32'(ram_a), 32'd0);
        chk("rst_ram_d", ram_d, 32'd0);

        // Word round trip
        run_op("sw40", 1'b1, SZ_WORD, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0, rd);
        run_op("lw40", 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b0, rd);
        chk("lw40_hand", rd, 32'hDEADBEEF);

        // Byte merge
        run_op("sw40b", 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h11223344, 1'b0, rd);
        run_op("sb42", 1'b1, SZ_BYTE, 1'b0, 32'h42, 32'h000000AA, 1'b0, rd);
        chk("sb42_mem", mem[16], 32'h11AA3344);

        // Sign/zero extension
        run_op("lb42s", 1'b0, SZ_BYTE, 1'b1, 32'h42, 32'h0, 1'b0, rd);
        chk("lb42s_hand", rd, 32'hFFFFFFAA);
        run_op("lb42u", 1'b0, SZ_BYTE, 1'b0, 32'h42, 32'h0, 1'b0, rd);
        chk("lb42u_hand", rd, 32'h000000AA);
        run_op("lh40s", 1'b0, SZ_HALF, 1'b1, 32'h40, 32'h0, 1'b0, rd);
        chk("lh40s_hand", rd, 32'h00003344);
        run_op("sh42", 1'b1, SZ_HALF, 1'b0, 32'h42, 32'h1234BEEF, 1'b0, rd);
        chk("sh42_mem", mem[16], 32'hBEEF3344);
        run_op("lh42s", 1'b0, SZ_HALF, 1'b1, 32'h42, 32'h0, 1'b0, rd);
        chk("lh42s_hand", rd, 32'hFFFFBEEF);
        run_op("lb43u", 1'b0, SZ_BYTE, 1'b0, 32'h43, 32'h0, 1'b0, rd);
        chk("lb43u_hand", rd, 32'h000000BE);

        // Misaligned word store
        run_op("sw41", 1'b1, SZ_WORD, 1'b0, 32'h41, 32'hCAFEF00D, 1'b0, rd);
`ifdef MAU_ALIGN_CHECK_EN
        chk("sw41_mem", mem[16], 32'hBEEF3344);
`else
        chk("sw41_mem", mem[16], 32'hCAFEF00D);
`endif

        // Reset during WRITE of a byte store
        run_op("sw80", 1'b1, SZ_WORD, 1'b0, 32'h80, 32'h11223344, 1'b0, rd);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
        req_addr = 32'h81; req_wdata = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rstw_state", 32'(dbg_state), 32'(WRITE));
        chk("rstw_we_before", 32'(ram_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstw_we_async", 32'(ram_we), 32'd0);
        rv_cnt = 0;
        repeat (3) begin @(negedge clk); rv_cnt += int'(resp_valid); end
        rst = 1'b0;
        @(negedge clk);
        rv_cnt += int'(resp_valid);
        chk("rstw_no_resp", 32'(rv_cnt), 32'd0);
        chk("rstw_mem", mem[32], 32'h11223344);
        run_op("lw80", 1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0, 1'b0, rd);
        chk("lw80_hand", rd, 32'h11223344);

        // Address wrap
        run_op("swwrap", 1'b1, SZ_WORD, 1'b0, 32'h0002_0000, 32'h0BADC0DE, 1'b0, rd);
        chk("swwrap_mem0", mem[0], 32'h0BADC0DE);
        run_op("lw0", 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, rd);
        chk("lw0_hand", rd, 32'h0BADC0DE);

        // Back-to-back random traffic with req_valid held high
        for (int i = 0; i < 20; i++) begin
            run_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)),
                   (32'($urandom_range(0, 3)) << 17) | 32'($urandom_range(0, 31)),
                   $urandom, 1'b1, rd);
        end
        req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
